// File: rtl/if_stage_pkg.sv
// Shared bus layouts and constants for the fetch stage and its neighbours.
package if_stage_pkg;

  localparam int PS_TO_FS_BUS_WD = 41;
  localparam int FS_TO_DS_BUS_WD = 72;

  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;

  typedef struct packed {
    logic        s0_ex;
    logic        s0_refill_ex;
    logic [5:0]  ecode;
    logic        ps_ex;
    logic [31:0] pc;
  } ps_to_fs_t;

  typedef struct packed {
    logic        fs_ex;
    logic        fs_refill;
    logic [5:0]  ecode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage_fs_inst_buf.sv
// One-entry skid buffer: parks an instruction that arrived while ID stalled,
// otherwise passes the SRAM word straight through.
module fs_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic        buf_valid,
  output logic [31:0] inst
);

  logic [31:0] buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_q     <= 32'h0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_q     <= rdata;
    end
  end

  assign inst = buf_valid ? buf_q : rdata;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: pairs pre-IF PCs with inst-SRAM responses, drops responses of
// cancelled/wrong-path requests, and hands {ex, inst, pc} to ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int CANCEL_CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps_to_fs_valid,
  input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
  output logic                       fs_allowin,
  input  logic                       ps_discard,
  input  logic                       data_ok,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       ds_allowin,
  input  logic                       br_flush,
  input  logic                       ws_flush,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  localparam logic [CANCEL_CNT_W-1:0] CNT_MAX = '1;

  logic                    fs_valid;
  ps_to_fs_t               fs_bus_r;
  logic [CANCEL_CNT_W-1:0] cancel_cnt, cnt_nxt;
  logic                    buf_valid;
  logic [31:0]             buf_inst;
  fs_to_ds_t               out_bus;

  logic fs_ex, flush, cnt_drop, hit, stray, ready_go, accept, handoff;
  logic cnt_inc, cnt_dec;

  assign fs_ex    = fs_bus_r.ps_ex;
  assign flush    = br_flush | ws_flush;
  assign cnt_drop = data_ok & (cancel_cnt != '0);
  assign hit      = data_ok & (cancel_cnt == '0) & ~ps_discard
                  & fs_valid & ~fs_ex & ~buf_valid;
  assign stray    = data_ok & (cancel_cnt == '0) & ~ps_discard & ~hit;

  assign ready_go       = fs_ex | buf_valid | hit;
  assign fs_allowin     = ~fs_valid | (ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & ready_go & ~flush;
  assign accept         = ps_to_fs_valid & fs_allowin;
  assign handoff        = fs_to_ds_valid & ds_allowin;

  fs_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (hit & ~ds_allowin & ~flush),
    .clear     (accept | flush | handoff),
    .rdata     (inst_sram_rdata),
    .buf_valid (buf_valid),
    .inst      (buf_inst)
  );

  // A flushed PC whose response is still outstanding owes us one drop.
  assign cnt_inc = flush & fs_valid & ~fs_ex & ~buf_valid & ~hit;
  assign cnt_dec = cnt_drop;

  always_comb begin
    cnt_nxt = cancel_cnt;
    if (cnt_inc && !cnt_dec)
      cnt_nxt = (cancel_cnt == CNT_MAX) ? cancel_cnt : cancel_cnt + 1'b1;
    else if (!cnt_inc && cnt_dec)
      cnt_nxt = cancel_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid   <= 1'b0;
      fs_bus_r   <= '0;
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cnt_nxt;
      if (accept) begin
        fs_valid <= 1'b1;
        fs_bus_r <= ps_to_fs_t'(ps_to_fs_bus);
      end else if (flush || handoff) begin
        fs_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!stray) else $error("if_stage: stray data_ok with no pending request");
      assert (!(cnt_inc && !cnt_dec && cancel_cnt == CNT_MAX))
        else $error("if_stage: cancel counter saturated");
    end
  end

  // Refill is only meaningful as a qualifier of a TLB-stage exception.
  always_comb begin
    out_bus.fs_ex     = fs_ex;
    out_bus.fs_refill = fs_bus_r.s0_refill_ex & fs_bus_r.s0_ex;
    out_bus.ecode     = fs_bus_r.ecode;
    out_bus.inst      = fs_ex ? 32'h0 : buf_inst;
    out_bus.pc        = fs_bus_r.pc;
  end

  assign fs_to_ds_bus = out_bus;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: normal fetch, ID stall, cancels, discards,
// pre-IF exceptions and flush/hit/accept collisions.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_to_fs_valid;
  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
  logic        fs_allowin;
  logic        ps_discard;
  logic        data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_flush;
  logic        ws_flush;
  logic        fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage #(.CANCEL_CNT_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .ps_to_fs_valid  (ps_to_fs_valid),
    .ps_to_fs_bus    (ps_to_fs_bus),
    .fs_allowin      (fs_allowin),
    .ps_discard      (ps_discard),
    .data_ok         (data_ok),
    .inst_sram_rdata (inst_sram_rdata),
    .ds_allowin      (ds_allowin),
    .br_flush        (br_flush),
    .ws_flush        (ws_flush),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] psb(input logic ex, input logic [5:0] ec, input logic [31:0] pc);
    return {1'b0, 1'b0, ec, ex, pc};
  endfunction

  function automatic logic [71:0] fsb(input logic ex, input logic [5:0] ec,
                                      input logic [31:0] inst, input logic [31:0] pc);
    return {ex, 1'b0, ec, inst, pc};
  endfunction

  // advance one cycle; inputs change and outputs are sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; ps_to_fs_valid = 1'b0; ps_to_fs_bus = '0; ps_discard = 1'b0;
    data_ok = 1'b0; inst_sram_rdata = 32'h0; ds_allowin = 1'b1;
    br_flush = 1'b0; ws_flush = 1'b0;
    tick(); tick();
    chk("rst_valid",   fs_to_ds_valid, 0);
    chk("rst_allowin", fs_allowin, 1);
    chk("rst_cnt",     dut.cancel_cnt, 0);
    reset = 1'b0;
    tick();

    // 1: normal fetch, data two cycles after accept, bypassed to ID
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c000000); settle();
    chk("t1_allowin_idle", fs_allowin, 1);
    tick(); ps_to_fs_valid = 1'b0; settle();
    chk("t1_wait_valid",   fs_to_ds_valid, 0);
    chk("t1_wait_allowin", fs_allowin, 0);
    tick(); data_ok = 1'b1; inst_sram_rdata = 32'h02800000; settle();
    chk("t1_hit_valid", fs_to_ds_valid, 1);
    chk("t1_hit_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h02800000, 32'h1c000000));
    chk("t1_hit_allow", fs_allowin, 1);
    tick(); data_ok = 1'b0; settle();
    chk("t1_after_valid", fs_to_ds_valid, 0);

    // 2: hit while ID stalls three cycles -> instruction buffered
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c000004);
    tick(); ps_to_fs_valid = 1'b0;
    data_ok = 1'b1; inst_sram_rdata = 32'h02800000; ds_allowin = 1'b0; settle();
    chk("t2_hit_valid", fs_to_ds_valid, 1);
    chk("t2_hit_allow", fs_allowin, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); data_ok = 1'b0; inst_sram_rdata = 32'hdeadbeef; settle();
      chk("t2_hold_valid", fs_to_ds_valid, 1);
      chk("t2_hold_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h02800000, 32'h1c000004));
      chk("t2_hold_allow", fs_allowin, 0);
    end
    tick(); ds_allowin = 1'b1; settle();
    chk("t2_rel_valid", fs_to_ds_valid, 1);
    chk("t2_rel_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h02800000, 32'h1c000004));
    chk("t2_rel_allow", fs_allowin, 1);
    tick(); settle();
    chk("t2_done_valid", fs_to_ds_valid, 0);

    // 3: br_flush before data_ok -> next response dropped
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c000008);
    tick(); ps_to_fs_valid = 1'b0; br_flush = 1'b1; settle();
    chk("t3_flush_valid", fs_to_ds_valid, 0);
    tick(); br_flush = 1'b0; settle();
    chk("t3_cnt1",       dut.cancel_cnt, 1);
    chk("t3_fs_allowin", fs_allowin, 1);
    data_ok = 1'b1; inst_sram_rdata = 32'h11111111; settle();
    chk("t3_drop_valid", fs_to_ds_valid, 0);
    tick(); data_ok = 1'b0; settle();
    chk("t3_cnt0", dut.cancel_cnt, 0);
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c00000c);
    tick(); ps_to_fs_valid = 1'b0; data_ok = 1'b1; inst_sram_rdata = 32'h22222222; settle();
    chk("t3_next_valid", fs_to_ds_valid, 1);
    chk("t3_next_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h22222222, 32'h1c00000c));
    tick(); data_ok = 1'b0;

    // 4: ps_discard drops a response while fs keeps waiting
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c000010);
    tick(); ps_to_fs_valid = 1'b0;
    ps_discard = 1'b1; data_ok = 1'b1; inst_sram_rdata = 32'h33333333; settle();
    chk("t4_disc_valid", fs_to_ds_valid, 0);
    chk("t4_disc_allow", fs_allowin, 0);
    tick(); ps_discard = 1'b0; data_ok = 1'b0; settle();
    chk("t4_wait_valid", fs_to_ds_valid, 0);
    chk("t4_cnt",        dut.cancel_cnt, 0);
    tick(); data_ok = 1'b1; inst_sram_rdata = 32'h44444444; settle();
    chk("t4_hit_valid", fs_to_ds_valid, 1);
    chk("t4_hit_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h44444444, 32'h1c000010));
    tick(); data_ok = 1'b0;

    // 5: pre-IF exception PC forwarded without data
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(1, ECODE_ADEF, 32'h1c000002);
    inst_sram_rdata = 32'h55aa55aa;
    tick(); ps_to_fs_valid = 1'b0; settle();
    chk("t5_ex_valid", fs_to_ds_valid, 1);
    chk("t5_ex_bus",   fs_to_ds_bus, fsb(1, 6'h08, 32'h0, 32'h1c000002));
    tick(); settle();
    chk("t5_done_valid", fs_to_ds_valid, 0);

    // 6: ws_flush with same-cycle hit and new accept
    ps_to_fs_valid = 1'b1; ps_to_fs_bus = psb(0, 6'h0, 32'h1c000020);
    tick();
    ps_to_fs_bus = psb(0, 6'h0, 32'h1c000030);
    data_ok = 1'b1; inst_sram_rdata = 32'h55555555; ws_flush = 1'b1; settle();
    chk("t6_col_valid", fs_to_ds_valid, 0);
    chk("t6_col_allow", fs_allowin, 1);
    tick(); ps_to_fs_valid = 1'b0; data_ok = 1'b0; ws_flush = 1'b0; settle();
    chk("t6_cnt",        dut.cancel_cnt, 0);
    chk("t6_hold_valid", fs_to_ds_valid, 0);
    chk("t6_hold_allow", fs_allowin, 0);
    data_ok = 1'b1; inst_sram_rdata = 32'h66666666; settle();
    chk("t6_new_valid", fs_to_ds_valid, 1);
    chk("t6_new_bus",   fs_to_ds_bus, fsb(0, 6'h0, 32'h66666666, 32'h1c000030));
    tick(); data_ok = 1'b0; settle();
    chk("t6_done_valid", fs_to_ds_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
